// File: rtl/l2_pkg.sv
// l2_pkg: shared definitions for the L2 cacheline adaptor.
//   - line/burst/address width constants and the beats-per-line count
//   - adaptor_state_t: adaptor FSM states
//   - align_line_addr(): clears the byte-offset bits of a line address
package l2_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_BURST  = 64;
  localparam int S_ADDR   = 32;
  localparam int LINE_W   = 8 * (2 ** S_OFFSET);
  localparam int BEATS    = LINE_W / S_BURST;
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adaptor_state_t;

  // Memory always works on whole lines, so the byte offset within the line
  // is dropped rather than passed through.
  function automatic logic [S_ADDR-1:0] align_line_addr(input logic [S_ADDR-1:0] addr);
    return {addr[S_ADDR-1:S_OFFSET], {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor: bridges the L2 data array's full-line port to a
// burst memory interface.
//   Fill:      4 memory beats are collected into line_o (ascending order,
//              beat 0 = bytes 0-7), then resp_o pulses for one cycle.
//   Writeback: line_i is captured at request time and streamed out on
//              burst_o, one beat per accepted resp_i, then resp_o pulses.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   line_i / line_o      writeback line in / assembled fill line out
//   address_i            request address from the L2 controller
//   read_i / write_i     fill / writeback requests (write wins if both)
//   resp_o               one-cycle completion pulse to the controller
//   burst_i / burst_o    memory read beat in / memory write beat out
//   address_o            line-aligned memory address
//   read_o / write_o     memory read / write requests (registered)
//   resp_i               memory beat-accept / beat-valid strobe
module l2_cacheline_adaptor
  import l2_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_burst  = S_BURST,
  parameter int s_addr   = S_ADDR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*(2**s_offset)-1:0] line_i,
  output logic [8*(2**s_offset)-1:0] line_o,
  input  logic [s_addr-1:0]          address_i,
  input  logic                       read_i,
  input  logic                       write_i,
  output logic                       resp_o,
  input  logic [s_burst-1:0]         burst_i,
  output logic [s_burst-1:0]         burst_o,
  output logic [s_addr-1:0]          address_o,
  output logic                       read_o,
  output logic                       write_o,
  input  logic                       resp_i
);

  localparam int LINE_BITS = 8 * (2 ** s_offset);
  localparam int NBEATS    = LINE_BITS / s_burst;
  localparam int CW        = $clog2(NBEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBEATS - 1);

  adaptor_state_t state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [LINE_BITS-1:0] line_buf;

  logic accept_write;
  logic accept_read;
  logic capture_beat;

  // A simultaneous read and write request resolves to the writeback; the
  // dropped read is re-issued by the controller.
  assign accept_write = (state == IDLE) && write_i;
  assign accept_read  = (state == IDLE) && !write_i && read_i;
  assign capture_beat = (state == READ) && resp_i;

  // Next-state logic. The beat counter advances only on resp_i, so memory
  // may insert any number of stall cycles between beats.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept_write) begin
          state_next = WRITE;
        end else if (accept_read) begin
          state_next = READ;
        end
      end
      READ, WRITE: begin
        if (resp_i) begin
          if (cnt == LAST_CNT) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State register and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Registered outputs and datapath. Request strobes and resp_o are decoded
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      line_buf  <= '0;
      line_o    <= '0;
    end else begin
      read_o  <= (state_next == READ);
      write_o <= (state_next == WRITE);
      resp_o  <= (state_next == DONE);
      if (accept_write || accept_read) begin
        address_o <= align_line_addr(address_i);
      end
      if (accept_write) begin
        line_buf <= line_i;
      end
      if (capture_beat) begin
        line_o[s_burst*cnt +: s_burst] <= burst_i;
      end
    end
  end

  // The write beat follows the counter combinationally so memory sees the
  // next beat as soon as the previous one is accepted.
  assign burst_o = write_o ? line_buf[s_burst*cnt +: s_burst] : '0;

endmodule

// File: doc/l2_cacheline_adaptor.md
Name: l2_cacheline_adaptor

Overview:
- Bridges the L2 data array's full-line port to the 64-bit burst memory interface.
- On a fill, collects 4 beats from memory and presents a 256-bit line, which the L2 controller writes into the data array.
- On a writeback, takes the 256-bit line read from the data array and streams it to memory as 4 beats.
- Sits directly between the L2 data array/controller and physical memory.

Parameters:
- s_offset, 5, log2 bytes per line (line = 8*2**s_offset bits = 256).
- s_burst, 64, memory beat width in bits.
- s_addr, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- line_i  in  256  line to write back (from data array dataout)
- line_o  out  256  assembled fill line (to data array datain)
- address_i  in  32  line request address from L2 controller
- read_i  in  1  fill request
- write_i  in  1  writeback request
- resp_o  out  1  one-cycle completion pulse to L2 controller
- burst_i  in  64  memory read beat
- burst_o  out  64  memory write beat
- address_o  out  32  line-aligned memory address
- read_o  out  1  memory read request
- write_o  out  1  memory write request
- resp_i  in  1  memory beat-accept/beat-valid strobe

Behaviour:
- Constant BEATS = 256/s_burst = 4; 2-bit beat counter cnt.
- Reset, asynchronous, active-high, any state:
  - state=IDLE, cnt=0.
  - line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
  - Internal line buffer=0.
  - An in-flight burst is abandoned; no partial data survives.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1: latch line_i into buffer and address_i into address_o with low s_offset bits forced to 0, then go to WRITE.
  - Else read_i=1: latch the address the same way, then go to READ.
  - read_i and write_i both high: write wins; the read is dropped and the controller must re-assert it.
  - resp_i is ignored in IDLE.
- READ:
  - read_o=1 (registered; high from the first cycle after the request is sampled).
  - Each cycle with resp_i=1: line_o[64*cnt +: 64] <= burst_i; cnt++.
  - On the beat with cnt==3: read_o<=0, cnt<=0, go to DONE.
  - resp_i=0 cycles stall: no capture, no increment. Beats need not be consecutive.
- WRITE:
  - write_o=1; burst_o = buffer[64*cnt +: 64] (combinational from cnt, valid whenever write_o=1).
  - Each resp_i=1 cycle: cnt++.
  - After the 4th accepted beat: write_o<=0, cnt<=0, go to DONE.
- DONE: resp_o=1 for exactly one cycle, then IDLE. read_o/write_o are already 0.
- line_o holds its last filled value until the next fill's first beat overwrites bytes 0-7. Writebacks never alter line_o.
- read_i/write_i outside IDLE are ignored. The controller holds them until resp_o; a still-asserted request in the cycle after DONE starts a new transaction.
- address_i/line_i are sampled only at request acceptance; later changes have no effect.
- Latency: request sampled at edge 0; mem req high from edge 0. With resp_i high on 4 consecutive cycles starting edge k, resp_o is high in the cycle after edge k+3. Minimum request-to-resp_o is 5 cycles.
- Beat order is always ascending (beat 0 = bytes 0-7). There is no critical-word-first ordering.

Decomposition:
- Shared package l2_pkg holds:
  - line/burst width constants and BEATS.
  - adaptor_state_t enum {IDLE, READ, WRITE, DONE}.
  - helper align_line_addr(addr) that zeroes the low s_offset bits.
- No sub-module: the counter, buffer and FSM are small enough to live in one module with separate next-state comb and state-register ff blocks.

Test Plan:
1. Fill: read_i, address_i=0x0000_1234; resp_i 4 consecutive cycles with burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220; line_o={0x44..,0x33..,0x22..,0x11..}; resp_o one pulse 5 cycles after the request.
2. Writeback: write_i, line_i=256'hDDDD..CCCC..BBBB..AAAA, resp_i gapped (1,0,1,1,0,1) -> burst_o sequence AAAA,BBBB,CCCC,DDDD on accepted beats; write_o drops after the 4th; resp_o pulses once.
3. Simultaneous read_i=write_i=1 -> WRITE performed, read_o never asserted; after resp_o, a held read_i starts a fill on the next cycle.
4. rst asserted mid-fill after 2 beats -> all outputs 0 asynchronously (before the next edge); a subsequent fill returns only new data, and cnt restarts at beat 0.
5. resp_i toggling in IDLE, and read_i changes mid-WRITE -> no state change, no capture, no spurious resp_o.
6. Back-to-back fills with different data -> line_o between transactions holds the first line intact until the second fill's first accepted beat.
